fifo_deq_serializer: RTL and testbench

Dequeue-side reader for the two-entry BSV-style FIFO (EMPTY_N/DEQ/D_OUT handshake). It pulls wide words out of the FIFO and emits them as narrow beats on a valid/ready stream. It sits between a wide producer's FIFO and a narrow consumer, such as a debug/trace port or a narrow bus bridge. It sustains one beat per cycle, with no bubble between consecutive words.

---
 rtl/fifo_deq_serializer.sv | 108 ++++++++++
 tb/tb_fifo_deq_serializer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_deq_serializer.sv
// Dequeues wide words from a two-entry BSV-style FIFO and streams them out as narrow valid/ready beats.
// Optional macro TXSER_MSB_FIRST_EN: emit the most-significant beat first (default is least-significant first).
module fifo_deq_serializer #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EMPTY_N,
  input  logic [IN_W-1:0]  FIFO_DATA,
  output logic             DEQ,
  input  logic             CLR,
  output logic             TX_VALID,
  input  logic             TX_READY,
  output logic [OUT_W-1:0] TX_DATA,
  output logic             TX_LAST,
  output logic             BUSY
);

  localparam int RATIO = IN_W / OUT_W;
  localparam int BW    = (RATIO > 2) ? $clog2(RATIO) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t          state_r;
  logic [BW-1:0]   beat_r;
  logic [IN_W-1:0] shift_r;
  logic            busy_s;
  logic            last_s;
  logic            deq_s;

  assign busy_s = (state_r == SEND);
  assign last_s = busy_s && (beat_r == LAST_BEAT);

  // Dequeue strobe: fetch from IDLE, or chain the next word on the final-beat handshake
  always_comb begin
    deq_s = 1'b0;
    if (RST || CLR) begin
      deq_s = 1'b0;
    end else if (state_r == IDLE) begin
      deq_s = EMPTY_N;
    end else if (TX_READY && last_s) begin
      deq_s = EMPTY_N;
    end else begin
      deq_s = 1'b0;
    end
  end

  // Controller state, beat counter and shift register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      beat_r  <= {BW{1'b0}};
      shift_r <= {IN_W{1'b0}};
    end else if (CLR) begin
      state_r <= IDLE;
      beat_r  <= {BW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (deq_s) begin
            shift_r <= FIFO_DATA;
            beat_r  <= {BW{1'b0}};
            state_r <= SEND;
          end
        end
        SEND: begin
          if (TX_READY) begin
            if (beat_r == LAST_BEAT) begin
              beat_r <= {BW{1'b0}};
              if (EMPTY_N) begin
                shift_r <= FIFO_DATA;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              beat_r <= beat_r + {{(BW-1){1'b0}}, 1'b1};
`ifdef TXSER_MSB_FIRST_EN
              shift_r <= {shift_r[IN_W-OUT_W-1:0], {OUT_W{1'b0}}};
`else
              shift_r <= {{OUT_W{1'b0}}, shift_r[IN_W-1:OUT_W]};
`endif
            end
          end
        end
        default: begin
          state_r <= IDLE;
          beat_r  <= {BW{1'b0}};
        end
      endcase
    end
  end

  assign DEQ      = deq_s;
  assign TX_VALID = busy_s;
  assign BUSY     = busy_s;
  assign TX_LAST  = last_s;
`ifdef TXSER_MSB_FIRST_EN
  assign TX_DATA  = busy_s ? shift_r[IN_W-1 -: OUT_W] : {OUT_W{1'b0}};
`else
  assign TX_DATA  = busy_s ? shift_r[OUT_W-1:0] : {OUT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Directed self-checking bench for fifo_deq_serializer with a queue-based FIFO model.
module tb_fifo_deq_serializer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        EMPTY_N;
  logic [31:0] FIFO_DATA;
  logic        DEQ;
  logic        CLR;
  logic        TX_VALID;
  logic        TX_READY;
  logic [7:0]  TX_DATA;
  logic        TX_LAST;
  logic        BUSY;

  logic [31:0] fifo_q[$];
  int total = 0;
  int bad   = 0;

  fifo_deq_serializer #(.IN_W(32), .OUT_W(8)) dut (
    .CLK(CLK), .RST(RST), .EMPTY_N(EMPTY_N), .FIFO_DATA(FIFO_DATA), .DEQ(DEQ),
    .CLR(CLR), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_DATA(TX_DATA),
    .TX_LAST(TX_LAST), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected beat i of a word in the configured order
  function automatic logic [7:0] exp_beat(input logic [31:0] w, input int i);
`ifdef TXSER_MSB_FIRST_EN
    return w[31 - 8*i -: 8];
`else
    return w[8*i +: 8];
`endif
  endfunction

  task automatic drive_fifo();
    EMPTY_N   = (fifo_q.size() != 0);
    FIFO_DATA = (fifo_q.size() != 0) ? fifo_q[0] : 32'h0;
  endtask

  // One clock: the FIFO model pops if DEQ was high before the edge
  task automatic step();
    logic d;
    d = DEQ;
    @(posedge CLK);
    #1;
    if (d && fifo_q.size() != 0) fifo_q.delete(0);
    drive_fifo();
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    drive_fifo();
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] data, input logic last, input logic deq);
    check_val({tag, "_valid"}, {31'h0, TX_VALID}, 32'h1);
    check_val({tag, "_busy"},  {31'h0, BUSY},     32'h1);
    check_val({tag, "_data"},  {24'h0, TX_DATA},  {24'h0, data});
    check_val({tag, "_last"},  {31'h0, TX_LAST},  {31'h0, last});
    check_val({tag, "_deq"},   {31'h0, DEQ},      {31'h0, deq});
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_valid"}, {31'h0, TX_VALID}, 32'h0);
    check_val({tag, "_busy"},  {31'h0, BUSY},     32'h0);
    check_val({tag, "_data"},  {24'h0, TX_DATA},  32'h0);
    check_val({tag, "_last"},  {31'h0, TX_LAST},  32'h0);
  endtask

  task automatic drain();
    for (int k = 0; k < 16 && TX_VALID; k++) step();
    check_val("drain_done", {31'h0, TX_VALID}, 32'h0);
  endtask

  logic [31:0] w;

  initial begin
    RST = 1'b1; CLR = 1'b0; TX_READY = 1'b1;
    drive_fifo();
    step();
    check_idle("reset");
    check_val("reset_deq_empty", {31'h0, DEQ}, 32'h0);

    // DEQ stays low while RST is high even with data waiting
    push(32'hDDCCBBAA);
    check_val("reset_deq_held", {31'h0, DEQ}, 32'h0);
    step();
    check_idle("reset2");
    RST = 1'b0;
    #1;

    // Single word
    check_val("single_deq", {31'h0, DEQ}, 32'h1);
    step();
    w = 32'hDDCCBBAA;
    for (int i = 0; i < 4; i++) begin
      check_beat($sformatf("single_b%0d", i), exp_beat(w, i), (i == 3), 1'b0);
      step();
    end
    check_idle("single_end");
    check_val("single_end_deq", {31'h0, DEQ}, 32'h0);

    // Back-to-back words, second DEQ on the last-beat handshake
    fifo_q.push_back(32'h03020100);
    push(32'h07060504);
    check_val("b2b_deq0", {31'h0, DEQ}, 32'h1);
    step();
    for (int i = 0; i < 8; i++) begin
      w = (i < 4) ? 32'h03020100 : 32'h07060504;
      check_beat($sformatf("b2b_b%0d", i), exp_beat(w, i % 4), (i == 3 || i == 7), (i == 3));
      step();
    end
    check_idle("b2b_end");

    // Backpressure on beat 1
    w = 32'h44332211;
    push(w);
    check_val("bp_deq", {31'h0, DEQ}, 32'h1);
    step();
    check_beat("bp_b0", exp_beat(w, 0), 1'b0, 1'b0);
    step();
    TX_READY = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_beat($sformatf("bp_stall%0d", i), exp_beat(w, 1), 1'b0, 1'b0);
      step();
    end
    TX_READY = 1'b1;
    #1;
    for (int i = 1; i < 4; i++) begin
      check_beat($sformatf("bp_b%0d", i), exp_beat(w, i), (i == 3), 1'b0);
      step();
    end
    check_idle("bp_end");

    // Empty FIFO for 10 cycles, then a word arrives
    for (int i = 0; i < 10; i++) begin
      check_val($sformatf("empty_deq%0d", i), {31'h0, DEQ}, 32'h0);
      check_val($sformatf("empty_valid%0d", i), {31'h0, TX_VALID}, 32'h0);
      step();
    end
    w = 32'h5A6B7C8D;
    push(w);
    check_val("arrive_deq", {31'h0, DEQ}, 32'h1);
    step();
    check_beat("arrive_b0", exp_beat(w, 0), 1'b0, 1'b0);
    drain();

    // CLR at beat 2 with another word waiting
    w = 32'hAABBCCDD;
    push(w);
    step();
    step();
    step();
    push(32'h11223344);
    check_beat("clr_b2", exp_beat(w, 2), 1'b0, 1'b0);
    CLR = 1'b1;
    #1;
    check_val("clr_cycle_deq", {31'h0, DEQ}, 32'h0);
    step();
    CLR = 1'b0;
    #1;
    check_idle("clr_after");
    check_val("clr_queue_kept", fifo_q.size(), 32'd1);
    check_val("clr_next_deq", {31'h0, DEQ}, 32'h1);

    // RST mid-word on the word that followed the flush
    w = 32'h11223344;
    step();
    step();
    check_beat("rst_b1", exp_beat(w, 1), 1'b0, 1'b0);
    push(32'hCAFEF00D);
    RST = 1'b1;
    #1;
    check_val("rst_cycle_deq", {31'h0, DEQ}, 32'h0);
    step();
    check_idle("rst_after");
    check_val("rst_after_deq", {31'h0, DEQ}, 32'h0);
    check_val("rst_queue_kept", fifo_q.size(), 32'd1);
    RST = 1'b0;
    #1;
    check_val("rst_resume_deq", {31'h0, DEQ}, 32'h1);
    step();
    check_beat("rst_resume_b0", exp_beat(32'hCAFEF00D, 0), 1'b0, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
